// File: rtl/ex_stage_alu_if.sv
// ex_stage_alu_if: ID/EX operand, forwarding and control inputs plus EX/MEM results of the execute stage.
interface ex_stage_alu_if #(
   parameter int WIDTH = 32
);
   logic             en;
   logic [1:0]       alu_op;
   logic             alu_src;
   logic [5:0]       funct;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic [WIDTH-1:0] imm;
   logic [WIDTH-1:0] mem_fwd;
   logic [WIDTH-1:0] wb_fwd;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic [3:0]       alu_ctl;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] store_q;
   logic             zero_q;
   logic             ovf_q;
   modport master (
      output en, alu_op, alu_src, funct, rs_val, rt_val, imm, mem_fwd, wb_fwd, fwd_a, fwd_b,
      input  alu_ctl, alu_res, res_q, store_q, zero_q, ovf_q
   );
   modport slave (
      input  en, alu_op, alu_src, funct, rs_val, rt_val, imm, mem_fwd, wb_fwd, fwd_a, fwd_b,
      output alu_ctl, alu_res, res_q, store_q, zero_q, ovf_q
   );
endinterface

// File: rtl/ex_stage_alu.sv
// ex_stage_alu: EX-stage operand forwarding, ALU decode/execute and EX/MEM result register.
// Define EX_ALU_OVERFLOW_EN to register signed ADD/SUB overflow on ovf_q (otherwise ovf_q is 0).
module ex_stage_alu #(
   parameter int WIDTH = 32
) (
   input logic clock,
   input logic reset_n,
   ex_stage_alu_if.slave bus
);
   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_XOR = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;
   localparam logic [3:0] OP_NOP = 4'b1111;
   logic [WIDTH-1:0] op_a, fwd_rt, op_b, res;
   logic [3:0]       fn_ctl, ctl;
   logic             ovf;
   always_comb begin
      op_a   = bus.fwd_a[1] ? (bus.fwd_a[0] ? '0 : bus.mem_fwd) : (bus.fwd_a[0] ? bus.wb_fwd : bus.rs_val);
      fwd_rt = bus.fwd_b[1] ? (bus.fwd_b[0] ? '0 : bus.mem_fwd) : (bus.fwd_b[0] ? bus.wb_fwd : bus.rt_val);
      op_b   = bus.alu_src ? bus.imm : fwd_rt;
   end
   always_comb begin
      fn_ctl = OP_NOP;
      case (bus.funct)
         6'b100000: fn_ctl = OP_ADD;
         6'b100010: fn_ctl = OP_SUB;
         6'b100100: fn_ctl = OP_AND;
         6'b100101: fn_ctl = OP_OR;
         6'b100110: fn_ctl = OP_XOR;
         6'b100111: fn_ctl = OP_NOR;
         6'b101010: fn_ctl = OP_SLT;
         default:   fn_ctl = OP_NOP;
      endcase
      ctl = bus.alu_op == 2'b10 ? fn_ctl : bus.alu_op == 2'b01 ? OP_SUB : OP_ADD;
   end
   always_comb begin
      res = '0;
      case (ctl)
         OP_ADD:  res = op_a + op_b;
         OP_SUB:  res = op_a - op_b;
         OP_AND:  res = op_a & op_b;
         OP_OR:   res = op_a | op_b;
         OP_XOR:  res = op_a ^ op_b;
         OP_NOR:  res = ~(op_a | op_b);
         OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         default: res = '0;
      endcase
   end
`ifdef EX_ALU_OVERFLOW_EN
   // Result sign compared to A covers both the ADD and SUB overflow rules.
   always_comb ovf = res[WIDTH-1] != op_a[WIDTH-1] &&
                     ((ctl == OP_ADD && op_a[WIDTH-1] == op_b[WIDTH-1]) ||
                      (ctl == OP_SUB && op_a[WIDTH-1] != op_b[WIDTH-1]));
`else
   assign ovf = 1'b0;
`endif
   assign bus.alu_ctl = ctl;
   assign bus.alu_res = res;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bus.res_q   <= '0;
         bus.store_q <= '0;
         bus.zero_q  <= 1'b0;
         bus.ovf_q   <= 1'b0;
      end else if (bus.en) begin
         bus.res_q   <= res;
         bus.store_q <= fwd_rt;
         bus.zero_q  <= res == '0;
         bus.ovf_q   <= ovf;
      end
   end
endmodule

// File: tb/tb_ex_stage_alu.sv
// tb_ex_stage_alu: directed vector table, reset/hold sequences and randomized checks against a reference model.
module tb_ex_stage_alu;
`ifdef EX_ALU_OVERFLOW_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif
   logic clock;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] e_res, e_store;
   logic        e_zero, e_ovf;

   ex_stage_alu_if #(.WIDTH(32)) bus ();
   ex_stage_alu #(.WIDTH(32)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [1:0]  op;
      logic        src;
      logic [5:0]  fn;
      logic [31:0] rs, rt, imm, mem, wb;
      logic [1:0]  fa, fb;
      logic [3:0]  ctl;
      logic [31:0] res, store;
      logic        ovf;
   } vec_t;
   vec_t vt[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_regs(input string tag);
      check({tag, " res_q"}, bus.res_q, e_res);
      check({tag, " store_q"}, bus.store_q, e_store);
      check({tag, " zero_q"}, 32'(bus.zero_q), 32'(e_zero));
      check({tag, " ovf_q"}, 32'(bus.ovf_q), 32'(e_ovf));
   endtask

   function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r, input logic [31:0] wb,
                                        input logic [31:0] mem);
      logic [31:0] src[4];
      src = '{r, wb, mem, 32'd0};
      return src[sel];
   endfunction

   // Reference: operation named from alu_op/funct, result from plain arithmetic, overflow from 64-bit sums.
   function automatic void model(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                                 input logic [31:0] b, output logic [3:0] ctl, output logic [31:0] r,
                                 output logic ov);
      longint sa, sb, wide;
      string  name;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (op != 2'b10) name = (op == 2'b01) ? "sub" : "add";
      else if (fn == 6'd32) name = "add";
      else if (fn == 6'd34) name = "sub";
      else if (fn == 6'd36) name = "and";
      else if (fn == 6'd37) name = "or";
      else if (fn == 6'd38) name = "xor";
      else if (fn == 6'd39) name = "nor";
      else if (fn == 6'd42) name = "slt";
      else name = "nop";
      ov = 1'b0;
      r = 32'd0;
      ctl = 4'hf;
      if (name == "add") begin ctl = 4'h2; wide = sa + sb; r = wide[31:0]; ov = wide > 64'sd2147483647 || wide < -64'sd2147483648; end
      if (name == "sub") begin ctl = 4'h6; wide = sa - sb; r = wide[31:0]; ov = wide > 64'sd2147483647 || wide < -64'sd2147483648; end
      if (name == "and") begin ctl = 4'h0; r = a & b; end
      if (name == "or")  begin ctl = 4'h1; r = a | b; end
      if (name == "xor") begin ctl = 4'h3; r = a ^ b; end
      if (name == "nor") begin ctl = 4'hc; r = ~(a | b); end
      if (name == "slt") begin ctl = 4'h7; r = (sa < sb) ? 32'd1 : 32'd0; end
      ov = ov & OVF_ON;
   endfunction

   task automatic drive(input vec_t v);
      bus.alu_op = v.op;  bus.alu_src = v.src; bus.funct = v.fn;
      bus.rs_val = v.rs;  bus.rt_val = v.rt;   bus.imm = v.imm;
      bus.mem_fwd = v.mem; bus.wb_fwd = v.wb;  bus.fwd_a = v.fa; bus.fwd_b = v.fb;
   endtask

   initial begin
      logic [31:0] corners[4];
      logic [3:0]  m_ctl;
      logic [31:0] m_res, m_a, m_b, m_rt;
      logic        m_ovf;
      vec_t        v;
      corners = '{32'h0, 32'h7fffffff, 32'h80000000, 32'hffffffff};
      vt[0]  = '{2'b00, 1'b0, 6'h00, 32'd5, 32'd7, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 4'h2, 32'd12, 32'd7, 1'b0};
      vt[1]  = '{2'b10, 1'b0, 6'b100010, 32'd3, 32'd4, 32'd0, 32'd20, 32'd20, 2'b10, 2'b01, 4'h6, 32'd0, 32'd20, 1'b0};
      vt[2]  = '{2'b10, 1'b0, 6'b100010, 32'd3, 32'd4, 32'd0, 32'd20, 32'd20, 2'b11, 2'b01, 4'h6, 32'hffffffec, 32'd20, 1'b0};
      vt[3]  = '{2'b11, 1'b1, 6'h3f, 32'd1, 32'd0, 32'hffffffff, 32'd9, 32'd0, 2'b00, 2'b10, 4'h2, 32'd0, 32'd9, 1'b0};
      vt[4]  = '{2'b10, 1'b0, 6'b101010, 32'h80000000, 32'd1, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 4'h7, 32'd1, 32'd1, 1'b0};
      vt[5]  = '{2'b10, 1'b0, 6'b100111, 32'h80000000, 32'd1, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 4'hc, 32'h7ffffffe, 32'd1, 1'b0};
      vt[6]  = '{2'b10, 1'b0, 6'b100110, 32'h80000000, 32'd1, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 4'h3, 32'h80000001, 32'd1, 1'b0};
      vt[7]  = '{2'b10, 1'b0, 6'b111111, 32'h80000000, 32'd1, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 4'hf, 32'd0, 32'd1, 1'b0};
      vt[8]  = '{2'b00, 1'b0, 6'h00, 32'h7fffffff, 32'd1, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 4'h2, 32'h80000000, 32'd1, 1'b1};
      vt[9]  = '{2'b01, 1'b0, 6'h00, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 4'h6, 32'hffffffff, 32'd1, 1'b0};
      vt[10] = '{2'b10, 1'b0, 6'b100100, 32'h0000f0f0, 32'h0000ff00, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 4'h0, 32'h0000f000, 32'h0000ff00, 1'b0};
      vt[11] = '{2'b10, 1'b0, 6'b100101, 32'h0000f0f0, 32'h0000ff00, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 4'h1, 32'h0000fff0, 32'h0000ff00, 1'b0};
      vt[12] = '{2'b01, 1'b0, 6'h00, 32'h80000000, 32'd1, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 4'h6, 32'h7fffffff, 32'd1, 1'b1};
      vt[13] = '{2'b00, 1'b0, 6'h00, 32'd100, 32'd5, 32'd0, 32'd0, 32'd50, 2'b01, 2'b00, 4'h2, 32'd55, 32'd5, 1'b0};
      reset_n = 1'b0;
      bus.en = 1'b1;
      drive(vt[0]);
      repeat (2) @(posedge clock);
      #1;
      e_res = 32'd0; e_store = 32'd0; e_zero = 1'b0; e_ovf = 1'b0;
      check_regs("reset");
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 14; i++) begin
         @(negedge clock);
         drive(vt[i]);
         #1;
         check($sformatf("vec%0d alu_ctl", i), 32'(bus.alu_ctl), 32'(vt[i].ctl));
         check($sformatf("vec%0d alu_res", i), bus.alu_res, vt[i].res);
         e_res = vt[i].res; e_store = vt[i].store; e_zero = vt[i].res == 32'd0; e_ovf = vt[i].ovf & OVF_ON;
         @(posedge clock);
         #1;
         check_regs($sformatf("vec%0d", i));
      end
      @(negedge clock);
      bus.en = 1'b0;
      drive(vt[2]);
      @(posedge clock);
      #1;
      check_regs("hold");
      @(negedge clock);
      bus.en = 1'b1;
      drive(vt[0]);
      #2 reset_n = 1'b0;
      #1;
      e_res = 32'd0; e_store = 32'd0; e_zero = 1'b0; e_ovf = 1'b0;
      check_regs("async reset");
      @(posedge clock);
      #1;
      check_regs("reset over edge");
      @(negedge clock);
      #1 reset_n = 1'b1;
      #1;
      check_regs("after release");
      @(posedge clock);
      #1;
      e_res = 32'd12; e_store = 32'd7;
      check_regs("resume");
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         v.op = 2'($urandom_range(0, 3));
         v.src = 1'($urandom_range(0, 1));
         v.fn = ($urandom_range(0, 9) < 7) ? 6'd32 + 6'($urandom_range(0, 10)) : 6'($urandom());
         v.rs = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom();
         v.rt = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom();
         v.imm = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom();
         v.mem = $urandom();
         v.wb = $urandom();
         v.fa = 2'($urandom_range(0, 3));
         v.fb = 2'($urandom_range(0, 3));
         drive(v);
         bus.en = ($urandom_range(0, 3) != 0);
         m_a = pick(v.fa, v.rs, v.wb, v.mem);
         m_rt = pick(v.fb, v.rt, v.wb, v.mem);
         m_b = v.src ? v.imm : m_rt;
         model(v.op, v.fn, m_a, m_b, m_ctl, m_res, m_ovf);
         #1;
         check($sformatf("rnd%0d alu_ctl", i), 32'(bus.alu_ctl), 32'(m_ctl));
         check($sformatf("rnd%0d alu_res", i), bus.alu_res, m_res);
         if (bus.en) begin
            e_res = m_res; e_store = m_rt; e_zero = m_res == 32'd0; e_ovf = m_ovf;
         end
         @(posedge clock);
         #1;
         check_regs($sformatf("rnd%0d", i));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ex_stage_alu.md
Name: ex_stage_alu

Overview:
- Execute-stage datapath slice of the 5-stage pipelined MIPS core.
- Selects forwarded operands through two 4:1 forwarding muxes and decodes the ALU operation from the 2-bit ALUOp plus the funct field.
- Computes a 32-bit result and registers result, store data and flags into the EX/MEM boundary.
- Sits between the ID/EX register and data memory; the forwarding selects come from the forwarding unit.

Parameters:
- WIDTH, 32, datapath width (operands, result, immediate).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  EX/MEM register load enable; 0 holds the registered outputs.
- alu_op  in  2  ALUOp from ID/EX control.
- alu_src  in  1  1 = operand B is the immediate.
- funct  in  6  immediate bits [5:0] (R-type funct).
- rs_val  in  WIDTH  ID/EX register A value.
- rt_val  in  WIDTH  ID/EX register B value.
- imm  in  WIDTH  sign-extended immediate.
- mem_fwd  in  WIDTH  EX/MEM ALU result, used for forwarding.
- wb_fwd  in  WIDTH  write-back data, used for forwarding.
- fwd_a  in  2  forwarding select for operand A.
- fwd_b  in  2  forwarding select for operand B.
- alu_ctl  out  4  decoded ALU control (combinational).
- alu_res  out  WIDTH  combinational ALU result.
- res_q  out  WIDTH  registered ALU result.
- store_q  out  WIDTH  registered store data (forwarded rt).
- zero_q  out  1  registered flag: result == 0.
- ovf_q  out  1  registered signed overflow (see Optional Feature).

Behaviour:
- Forwarding mux, identical for A and B:
  - sel 00 → register value (rs_val or rt_val).
  - sel 01 → wb_fwd.
  - sel 10 → mem_fwd.
  - sel 11 → constant 0.
- Operand B:
  - fwd_b applies to rt_val first, giving fwd_rt.
  - srcB = alu_src ? imm : fwd_rt. The immediate is never overridden by forwarding.
  - store_q captures fwd_rt.
- ALU control decode:
  - alu_op 00 → ADD (0010).
  - alu_op 01 → SUB (0110).
  - alu_op 11 → ADD (0010), used for immediate arithmetic.
  - alu_op 10 → decode funct:
    - 100000 → ADD 0010.
    - 100010 → SUB 0110.
    - 100100 → AND 0000.
    - 100101 → OR 0001.
    - 100110 → XOR 0011.
    - 100111 → NOR 1100.
    - 101010 → SLT 0111.
    - any other funct → NOP 1111.
- ALU operations:
  - ADD and SUB are modulo 2^WIDTH.
  - AND, OR, XOR, NOR are bitwise.
  - SLT is a signed compare: result = {31'b0, A<B}.
  - NOP, or any code not listed above, → result 0.
- The combinational path from inputs to alu_ctl and alu_res has no latency.
- Registers: on posedge clock with en=1, res_q, store_q, zero_q and ovf_q load the current values; with en=0 they hold.
- Reset: reset_n low at any time immediately clears res_q, store_q, zero_q and ovf_q to 0, regardless of clock or en.
- Reset mid-operation discards any in-flight result. Loading resumes at the first rising edge after reset_n returns high.
- Boundaries:
  - 0x7FFFFFFF + 1 wraps to 0x80000000.
  - 0 − 1 = 0xFFFFFFFF.
  - SLT 0x80000000 < 0x00000001 gives 1 (signed).
  - zero_q = 1 when the result is 0, including the NOP result.

Optional Feature:
- Macro: EX_ALU_OVERFLOW_EN.
- When defined: ovf_q registers signed overflow for ADD and SUB.
  - ADD overflow: operands share a sign and the result sign differs.
  - SUB overflow: operands differ in sign and the result sign differs from A.
  - ovf_q = 0 for all other operations.
- When undefined: ovf_q is tied to constant 0 and no overflow logic is synthesized.

Test Plan:
- ADD with no forwarding: alu_op=00, alu_src=0, rs_val=5, rt_val=7 → alu_ctl=0010, alu_res=12; after a clock with en=1, res_q=12 and zero_q=0.
- Forwarding: alu_op=10, funct=100010, fwd_a=10 (mem_fwd=20), fwd_b=01 (wb_fwd=20) → alu_res=0, zero_q=1; with fwd_a=11 the result is 0−20 = 0xFFFFFFEC.
- Immediate with forwarding: alu_src=1, imm=0xFFFFFFFF, fwd_b=10, mem_fwd=9, alu_op=11, rs_val=1 → alu_res=0 (immediate used, not forwarded); store_q=9.
- Logic ops and SLT: rs=0x80000000, rt=1:
  - funct 101010 → 1.
  - funct 100111 → 0x7FFFFFFE.
  - funct 100110 → 0x80000001.
  - funct 111111 → 0.
- Overflow: ADD 0x7FFFFFFF + 1 → res_q=0x80000000; ovf_q=1 with EX_ALU_OVERFLOW_EN defined, 0 without it.
- Hold and reset: set en=0 and change operands → registered outputs hold. Pulse reset_n low between clock edges → all registered outputs read 0 immediately.
